// File: rtl/serial_pattern_shifter_pkg.sv
// Shared types and constants for the serial pattern shifter.
// The optional latch phase is selected by the SERIAL_STROBE_EN macro in the top.
package serial_shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_e;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_ROTATE  = 1'b1;

endpackage

// File: rtl/serial_pattern_shifter_clk_tick_gen.sv
// Half-period tick generator: pulses tick_o every div_i+1 cycles while run_i is high.
// Reusable by other LED/serial blocks that need a divided strobe.
module clk_tick_gen #(
    parameter int DIV_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 restart_i,
    input  logic                 run_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 tick_o
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;

    assign tick_o = run_i & (cnt_q == div_i);

    // Counter next state: restart wins, then wrap on tick, else count while running.
    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = {DIV_WIDTH{1'b0}};
        end else if (run_i) begin
            if (tick_o) begin
                cnt_d = {DIV_WIDTH{1'b0}};
            end else begin
                cnt_d = cnt_q + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {DIV_WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_pattern_shifter.sv
// Multi-channel MSB-first serial pattern generator with shared divided sclk, one-shot or rotate.
// Define SERIAL_STROBE_EN to add a one-half-period LATCH phase with a strobe pulse per word.
module serial_pattern_shifter
    import serial_shift_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 1,
    parameter int DIV_WIDTH = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [DIV_WIDTH-1:0]      div,
    input  logic                      mode,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [CHANNELS*WIDTH-1:0] load_data,
    output logic                      sclk,
    output logic [CHANNELS-1:0]       sdata,
    output logic                      busy,
    output logic                      word_done,
    output logic                      strobe
);

    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    state_e                            state_q, state_d;
    logic [DIV_WIDTH-1:0]              div_q, div_d;
    logic                              mode_q, mode_d;
    logic [CHANNELS-1:0][WIDTH-1:0]    shreg_q, shreg_d;
    logic [BIT_W-1:0]                  bit_cnt_q, bit_cnt_d;
    logic                              sclk_q, sclk_d;
    logic                              busy_q, busy_d;
    logic                              word_done_q, word_done_d;
    logic                              accept_s;
    logic                              tick_s;
    logic                              continue_s;
    logic [CHANNELS-1:0][WIDTH-1:0]    shifted_s;

    assign load_ready = enable & (state_q == IDLE);
    assign accept_s   = load_valid & load_ready;
    assign continue_s = (mode_q == MODE_ROTATE) & enable;
    assign sclk       = sclk_q;
    assign busy       = busy_q;
    assign word_done  = word_done_q;

    clk_tick_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_tick (
        .clk       (clk),
        .rst       (rst),
        .restart_i (accept_s),
        .run_i     (state_q != IDLE),
        .div_i     (div_q),
        .tick_o    (tick_s)
    );

    // Per-lane MSB and next shifted value; rotate recirculates the MSB so the pattern self-restores.
    always_comb begin
        sdata     = {CHANNELS{1'b0}};
        shifted_s = shreg_q;
        for (int c = 0; c < CHANNELS; c++) begin
            sdata[c] = shreg_q[c][WIDTH-1];
            if (mode_q == MODE_ROTATE) begin
                shifted_s[c] = {shreg_q[c][WIDTH-2:0], shreg_q[c][WIDTH-1]};
            end else begin
                shifted_s[c] = {shreg_q[c][WIDTH-2:0], 1'b0};
            end
        end
    end

`ifdef SERIAL_STROBE_EN
    logic strobe_q, strobe_d;
    assign strobe = strobe_q;
`else
    assign strobe = 1'b0;
`endif

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        mode_d      = mode_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        sclk_d      = sclk_q;
        busy_d      = busy_q;
        word_done_d = 1'b0;
`ifdef SERIAL_STROBE_EN
        strobe_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d   = SHIFT;
                    div_d     = div;
                    mode_d    = mode;
                    shreg_d   = load_data;
                    bit_cnt_d = LAST_BIT;
                    sclk_d    = 1'b0;
                    busy_d    = 1'b1;
                end else begin
                    busy_d    = 1'b0;
                end
            end
            SHIFT: begin
                if (!tick_s) begin
                    state_d = SHIFT;
                end else if (!sclk_q) begin
                    sclk_d = 1'b1;
                end else begin
                    sclk_d  = 1'b0;
                    shreg_d = shifted_s;
                    if (bit_cnt_q == {BIT_W{1'b0}}) begin
                        bit_cnt_d = LAST_BIT;
`ifdef SERIAL_STROBE_EN
                        state_d  = LATCH;
                        strobe_d = 1'b1;
`else
                        word_done_d = 1'b1;
                        if (continue_s) begin
                            state_d = SHIFT;
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q - BIT_W'(1);
                    end
                end
            end
`ifdef SERIAL_STROBE_EN
            LATCH: begin
                if (tick_s) begin
                    word_done_d = 1'b1;
                    if (continue_s) begin
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    strobe_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                sclk_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            div_q       <= {DIV_WIDTH{1'b0}};
            mode_q      <= MODE_ONESHOT;
            shreg_q     <= {(CHANNELS*WIDTH){1'b0}};
            bit_cnt_q   <= {BIT_W{1'b0}};
            sclk_q      <= 1'b0;
            busy_q      <= 1'b0;
            word_done_q <= 1'b0;
`ifdef SERIAL_STROBE_EN
            strobe_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            mode_q      <= mode_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            sclk_q      <= sclk_d;
            busy_q      <= busy_d;
            word_done_q <= word_done_d;
`ifdef SERIAL_STROBE_EN
            strobe_q    <= strobe_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_pattern_shifter.sv
// Directed, table-driven bench for serial_pattern_shifter (WIDTH=8, CHANNELS=2).
// Expected word times follow SERIAL_STROBE_EN when the bench is built with it.
module tb_serial_pattern_shifter;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [23:0] div;
    logic        mode;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic        sclk;
    logic [1:0]  sdata;
    logic        busy;
    logic        word_done;
    logic        strobe;

    int checks = 0;
    int errors = 0;

    serial_pattern_shifter #(
        .WIDTH     (8),
        .CHANNELS  (2),
        .DIV_WIDTH (24)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .div        (div),
        .mode       (mode),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .sclk       (sclk),
        .sdata      (sdata),
        .busy       (busy),
        .word_done  (word_done),
        .strobe     (strobe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [23:0] dv;
        logic [7:0]  exp0;
        logic [7:0]  exp1;
        int          period;
        int          word_ns;
        int          word_st;
    } vec_t;

    vec_t vecs [4];

`ifdef SERIAL_STROBE_EN
    localparam int WT          = 34;
    localparam int EXP_GAPS    = 3;
    localparam int EXP_STROBES = 8;
`else
    localparam int WT          = 32;
    localparam int EXP_GAPS    = 0;
    localparam int EXP_STROBES = 0;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!load_ready && n < 50) begin
            step();
            n++;
        end
        check("ready_before_load", load_ready, 1);
    endtask

    initial begin
        int cyc, nrise, r1, r2, done_cyc, wd_cnt, last_rise, bad_gaps, strobes, busy_fall;
        int wd_cyc [4];
        logic [7:0]  b0, b1;
        logic [31:0] s0, s1;
        logic        prev;

        vecs[0] = '{16'h00CC, 24'd0, 8'hCC, 8'h00, 2, 16, 17};
        vecs[1] = '{16'hF00F, 24'd2, 8'h0F, 8'hF0, 6, 48, 51};
        vecs[2] = '{16'hA55A, 24'd1, 8'h5A, 8'hA5, 4, 32, 34};
        vecs[3] = '{16'h8001, 24'd3, 8'h01, 8'h80, 8, 64, 68};

        rst = 1'b1; enable = 1'b1; div = 24'd0; mode = 1'b0;
        load_valid = 1'b0; load_data = 16'h0000;
        repeat (2) step();
        check("rst_sclk", sclk, 0);
        check("rst_sdata", sdata, 0);
        check("rst_busy", busy, 0);
        check("rst_word_done", word_done, 0);
        check("rst_strobe", strobe, 0);
        check("rst_load_ready", load_ready, 1);
        rst = 1'b0;
        step();

        // One-shot words from the table; div/mode are disturbed after accept and must be ignored.
        for (int i = 0; i < 4; i++) begin
            wait_ready();
            load_data = vecs[i].data; div = vecs[i].dv; mode = 1'b0; load_valid = 1'b1;
            step();
            load_valid = 1'b0; div = 24'd0; mode = 1'b1;
            check("accept_busy", busy, 1);
            check("accept_sclk", sclk, 0);
            check("accept_sdata", sdata, {vecs[i].exp1[7], vecs[i].exp0[7]});
            cyc = 0; prev = sclk; nrise = 0; r1 = 0; r2 = 0; done_cyc = -1; b0 = 8'h00; b1 = 8'h00;
            while (done_cyc < 0 && cyc < 400) begin
                step();
                cyc++;
                if (sclk && !prev) begin
                    if (nrise < 8) begin
                        b0 = {b0[6:0], sdata[0]};
                        b1 = {b1[6:0], sdata[1]};
                    end
                    if (nrise == 0) r1 = cyc;
                    if (nrise == 1) r2 = cyc;
                    nrise++;
                end
                prev = sclk;
                if (cyc == 3) check("busy_no_ready", load_ready, 0);
                if (word_done) done_cyc = cyc;
            end
            check("lane0_bits", b0, vecs[i].exp0);
            check("lane1_bits", b1, vecs[i].exp1);
            check("sclk_period", r2 - r1, vecs[i].period);
            check("rise_count", nrise, 8);
`ifdef SERIAL_STROBE_EN
            check("word_time", done_cyc, vecs[i].word_st);
`else
            check("word_time", done_cyc, vecs[i].word_ns);
`endif
            check("done_busy", busy, 0);
            check("done_sdata", sdata, 0);
            check("done_ready", load_ready, 1);
        end

        // Reset in the middle of a div=3 word aborts without word_done.
        wait_ready();
        load_data = 16'h55CC; div = 24'd3; mode = 1'b0; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        repeat (10) step();
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        step();
        check("midrst_sclk", sclk, 0);
        check("midrst_sdata", sdata, 0);
        check("midrst_busy", busy, 0);
        check("midrst_word_done", word_done, 0);
        check("midrst_ready", load_ready, 1);
        rst = 1'b0;
        wd_cnt = 0;
        for (int k = 0; k < 80; k++) begin
            step();
            if (word_done || busy) wd_cnt++;
        end
        check("post_rst_quiet", wd_cnt, 0);

        // Rotate 0x81 / 0x3C with div=1, enable dropped during the fourth word.
        wait_ready();
        load_data = 16'h3C81; div = 24'd1; mode = 1'b1; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        cyc = 0; prev = sclk; nrise = 0; wd_cnt = 0; last_rise = 0; bad_gaps = 0; strobes = 0;
        busy_fall = -1; s0 = 32'h0; s1 = 32'h0;
        for (int k = 0; k < 4; k++) wd_cyc[k] = -1;
        while (busy_fall < 0 && cyc < 600) begin
            step();
            cyc++;
            if (sclk && !prev) begin
                if (nrise < 32) begin
                    s0 = {s0[30:0], sdata[0]};
                    s1 = {s1[30:0], sdata[1]};
                end
                if (nrise > 0 && (cyc - last_rise) != 4) bad_gaps++;
                last_rise = cyc;
                nrise++;
            end
            prev = sclk;
            if (strobe) strobes++;
            if (word_done) begin
                if (wd_cnt < 4) wd_cyc[wd_cnt] = cyc;
                wd_cnt++;
            end
            if (cyc == 3 * WT + 11) begin
                check("rot_drop_ready", load_ready, 0);
                check("rot_drop_busy", busy, 1);
            end
            if (cyc == 3 * WT + 10) enable = 1'b0;
            if (!busy) busy_fall = cyc;
        end
        check("rot_lane0", s0, 32'h81818181);
        check("rot_lane1", s1, 32'h3C3C3C3C);
        check("rot_rises", nrise, 32);
        check("rot_gaps", bad_gaps, EXP_GAPS);
        check("rot_strobes", strobes, EXP_STROBES);
        check("rot_wd_count", wd_cnt, 4);
        check("rot_wd0", wd_cyc[0], WT);
        check("rot_wd1", wd_cyc[1], 2 * WT);
        check("rot_wd2", wd_cyc[2], 3 * WT);
        check("rot_wd3", wd_cyc[3], 4 * WT);
        check("rot_busy_fall", busy_fall, 4 * WT);
        repeat (3) step();
        check("rot_ready_held_low", load_ready, 0);
        check("rot_idle_busy", busy, 0);
        enable = 1'b1;
        #1;
        check("rot_ready_enable", load_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
